// File: rtl/mul_share_arb_pkg.sv
// Shared constants and FSM encoding
// for the multiplier-share arbiter.
package mul_share_arb_pkg;

  localparam int MUL_W = 32;
  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mul_rr_pick.sv
// Round-robin pick: first request
// after ptr, wrapping modulo N.
module mul_rr_pick
  import mul_share_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  localparam logic [PW:0] NW = (PW+1)'(N);

  logic [PW:0]   sum;
  logic [PW-1:0] j;

  // scan far-to-near so the nearest
  // requester after ptr wins last
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = N; k >= 1; k--) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= NW) sum = sum - NW;
      j = sum[PW-1:0];
      if (req_i[j]) begin
        idx_o = j;
        any_o = 1'b1;
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin share of one iterative 32x32 multiplier among N requesters.
// Build option: define MULARB_TIMEOUT_EN to bound the wait for mul_ack.
module mul_share_arb
  import mul_share_arb_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*MUL_W-1:0] p0_in,
  input  logic [N*MUL_W-1:0] p1_in,
  output logic [N-1:0]       ack,
  output logic [MUL_W-1:0]   out,
  output logic               err,
  output logic               mul_req,
  output logic [MUL_W-1:0]   mul_p0,
  output logic [MUL_W-1:0]   mul_p1,
  input  logic               mul_ack,
  input  logic [MUL_W-1:0]   mul_out
);

  localparam int PW = $clog2(N);

  if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_chk
    $error("mul_share_arb: N must be 2..8, TIMEOUT >= 1");
  end

  arb_state_e       state_q;
  logic [PW-1:0]    ptr_q;
  logic [N-1:0]     gsel_q;
  logic [N-1:0]     ack_q;
  logic             mul_req_q;
  logic [MUL_W-1:0] p0_q;
  logic [MUL_W-1:0] p1_q;
  logic [MUL_W-1:0] out_q;

  logic [N-1:0]     pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

`ifdef MULARB_TIMEOUT_EN
  localparam int CW =
    ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;
`endif

  mul_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // grant / issue / complete sequencer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= PW'(N - 1);
      gsel_q    <= '0;
      ack_q     <= '0;
      mul_req_q <= 1'b0;
      p0_q      <= '0;
      p1_q      <= '0;
      out_q     <= '0;
`ifdef MULARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (pick_any) begin
            p0_q      <= p0_in[pick_idx*MUL_W +: MUL_W];
            p1_q      <= p1_in[pick_idx*MUL_W +: MUL_W];
            ptr_q     <= pick_idx;
            gsel_q    <= pick_gnt;
            mul_req_q <= 1'b1;
            state_q   <= S_ISSUE;
`ifdef MULARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        S_ISSUE: begin
          if (mul_ack) begin
            out_q     <= mul_out;
            mul_req_q <= 1'b0;
            ack_q     <= gsel_q;
            state_q   <= S_DONE;
`ifdef MULARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
`ifdef MULARB_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            out_q     <= '0;
            mul_req_q <= 1'b0;
            ack_q     <= gsel_q;
            err_q     <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
`ifdef MULARB_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack     = ack_q;
  assign out     = out_q;
  assign mul_req = mul_req_q;
  assign mul_p0  = p0_q;
  assign mul_p1  = p1_q;
`ifdef MULARB_TIMEOUT_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb
// with a latency-programmable unit model.
module tb_mul_share_arb;

  localparam int N  = 4;
  localparam int TO = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req;
  logic [N*32-1:0] p0_in;
  logic [N*32-1:0] p1_in;
  logic [N-1:0]    ack;
  logic [31:0]     out;
  logic            err;
  logic            mul_req;
  logic [31:0]     mul_p0;
  logic [31:0]     mul_p1;
  logic            mul_ack;
  logic [31:0]     mul_out;

  logic            u_ack;
  logic [31:0]     u_out;
  int              ucnt;
  int              lat  = 5;
  bit              u_en = 1'b1;
  logic            f_ack = 1'b0;
  logic [31:0]     f_out = '0;

  int errors = 0;
  int checks = 0;
  int ref_ptr = N - 1;
  logic [31:0] ea [N];
  logic [31:0] eb [N];

  always #5 clk = ~clk;

  assign mul_ack = u_ack | f_ack;
  assign mul_out = u_ack ? u_out : f_out;

  mul_share_arb #(.N(N), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .p0_in   (p0_in),
    .p1_in   (p1_in),
    .ack     (ack),
    .out     (out),
    .err     (err),
    .mul_req (mul_req),
    .mul_p0  (mul_p0),
    .mul_p1  (mul_p1),
    .mul_ack (mul_ack),
    .mul_out (mul_out)
  );

  // unit model: ack after lat sampled cycles of mul_req
  always @(posedge clk) begin
    if (!rst) begin
      u_ack <= 1'b0;
      ucnt  <= 0;
    end else if (u_ack) begin
      u_ack <= 1'b0;
      ucnt  <= 0;
    end else if (mul_req && u_en) begin
      if (ucnt + 1 >= lat) begin
        u_ack <= 1'b1;
        u_out <= mul_p0 * mul_p1;
        ucnt  <= 0;
      end else begin
        ucnt <= ucnt + 1;
      end
    end else begin
      ucnt <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] prod(input logic [31:0] a,
                                       input logic [31:0] b);
    logic [63:0] f;
    f = {32'b0, a} * {32'b0, b};
    return f[31:0];
  endfunction

  function automatic int rr(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b);
    p0_in[i*32 +: 32] = a;
    p1_in[i*32 +: 32] = b;
    ea[i] = a;
    eb[i] = b;
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    repeat (2) tick();
    rst = 1'b1;
    ref_ptr = N - 1;
  endtask

  task automatic test_reset();
    req = '0;
    p0_in = '0;
    p1_in = '0;
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (mul_req !== 1'b0) begin
      errors++; $display("FAIL reset_mul_req got=%b exp=0", mul_req);
    end
    checks++;
    if (ack !== '0) begin
      errors++; $display("FAIL reset_ack got=%b exp=0", ack);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err got=%b exp=0", err);
    end
    checks++;
    if (out !== '0 || mul_p0 !== '0 || mul_p1 !== '0) begin
      errors++;
      $display("FAIL reset_data got out=%h p0=%h p1=%h exp=0",
               out, mul_p0, mul_p1);
    end
    rst = 1'b1;
    ref_ptr = N - 1;
    tick();
  endtask

  task automatic test_single();
    set_op(0, 32'd7, 32'd6);
    lat = 5;
    req = 4'b0001;
    tick();
    checks++;
    if (mul_req !== 1'b1 || mul_p0 !== 32'd7 || mul_p1 !== 32'd6) begin
      errors++;
      $display("FAIL single_issue got req=%b p0=%0d p1=%0d exp 1/7/6",
               mul_req, mul_p0, mul_p1);
    end
    repeat (5) tick();
    checks++;
    if (ack !== '0) begin
      errors++; $display("FAIL single_early_ack got=%b exp=0000", ack);
    end
    tick();
    checks++;
    if (ack !== 4'b0001 || out !== 32'd42) begin
      errors++;
      $display("FAIL single_done got ack=%b out=%0d exp 0001/42", ack, out);
    end
    checks++;
    if (mul_req !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_done_ctl got req=%b err=%b exp 0/0",
               mul_req, err);
    end
    req[0] = 1'b0;
    ref_ptr = 0;
    tick();
    checks++;
    if (ack !== '0 || out !== 32'd42) begin
      errors++;
      $display("FAIL single_hold got ack=%b out=%0d exp 0000/42", ack, out);
    end
    tick();
  endtask

  task automatic test_contention();
    bit ok;
    int g;
    int low;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 2), 32'(i + 3));
    lat = 3;
    req = '1;
    for (int op = 0; op < 5; op++) begin
      g = rr(req, ref_ptr);
      wait_ack(40, ok);
      checks++;
      if (!ok || ack !== oh(g) || out !== prod(ea[g], eb[g])) begin
        errors++;
        $display("FAIL contention_op%0d got ack=%b out=%0d exp %b/%0d",
                 op, ack, out, oh(g), prod(ea[g], eb[g]));
      end
      ref_ptr = g;
      if (op < 4) begin
        low = 1;
        for (int c = 0; c < 10; c++) begin
          tick();
          if (mul_req) break;
          low++;
        end
        checks++;
        if (low < 2) begin
          errors++;
          $display("FAIL contention_gap got=%0d exp>=2", low);
        end
      end
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    bit ok;
    int g;
    lat = 2;
    set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req = 4'b0100;
    g = rr(req, ref_ptr);
    wait_ack(40, ok);
    checks++;
    if (!ok || ack !== 4'b0100 || out !== 32'h0000_0001) begin
      errors++;
      $display("FAIL wrap_trunc got ack=%b out=%h exp 0100/00000001",
               ack, out);
    end
    ref_ptr = g;
    set_op(0, 32'd5, 32'd9);
    set_op(1, 32'd11, 32'd13);
    req = 4'b0011;
    for (int op = 0; op < 2; op++) begin
      g = rr(req, ref_ptr);
      wait_ack(40, ok);
      checks++;
      if (!ok || ack !== oh(g) || out !== prod(ea[g], eb[g])) begin
        errors++;
        $display("FAIL wrap_order%0d got ack=%b out=%0d exp %b/%0d",
                 op, ack, out, oh(g), prod(ea[g], eb[g]));
      end
      ref_ptr = g;
      req[g] = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int g;
    set_op(3, 32'd100, 32'd200);
    lat = 20;
    req = 4'b1000;
    tick();
    checks++;
    if (mul_req !== 1'b1 || mul_p0 !== 32'd100) begin
      errors++;
      $display("FAIL rstmid_issue got req=%b p0=%0d exp 1/100",
               mul_req, mul_p0);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (mul_req !== 1'b0 || ack !== '0 || out !== '0 || mul_p0 !== '0) begin
      errors++;
      $display("FAIL rstmid_clear got req=%b ack=%b out=%0d p0=%0d exp 0",
               mul_req, ack, out, mul_p0);
    end
    rst = 1'b1;
    ref_ptr = N - 1;
    lat = 4;
    set_op(0, 32'd21, 32'd2);
    req = 4'b1001;
    tick();
    checks++;
    if (mul_req !== 1'b1 || mul_p0 !== 32'd21) begin
      errors++;
      $display("FAIL rstmid_first got req=%b p0=%0d exp 1/21",
               mul_req, mul_p0);
    end
    for (int op = 0; op < 2; op++) begin
      g = rr(req, ref_ptr);
      wait_ack(40, ok);
      checks++;
      if (!ok || ack !== oh(g) || out !== prod(ea[g], eb[g])) begin
        errors++;
        $display("FAIL rstmid_op%0d got ack=%b out=%0d exp %b/%0d",
                 op, ack, out, oh(g), prod(ea[g], eb[g]));
      end
      ref_ptr = g;
      req[g] = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic test_spurious();
    bit ok;
    logic [31:0] prev;
    prev = out;
    f_out = 32'hDEAD_BEEF;
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
    checks++;
    if (ack !== '0 || out !== prev || mul_req !== 1'b0) begin
      errors++;
      $display("FAIL spur_idle got ack=%b out=%h req=%b exp 0000/%h/0",
               ack, out, mul_req, prev);
    end
    tick();
    set_op(1, 32'd7, 32'd8);
    lat = 2;
    req = 4'b0010;
    tick();
    checks++;
    if (mul_req !== 1'b1 || mul_p0 !== 32'd7) begin
      errors++;
      $display("FAIL spur_still_idle got req=%b p0=%0d exp 1/7",
               mul_req, mul_p0);
    end
    wait_ack(20, ok);
    checks++;
    if (!ok || ack !== 4'b0010 || out !== 32'd56) begin
      errors++;
      $display("FAIL spur_op got ack=%b out=%0d exp 0010/56", ack, out);
    end
    ref_ptr = 1;
    req = '0;
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
    tick();
    checks++;
    if (ack !== '0 || out !== 32'd56 || mul_req !== 1'b0) begin
      errors++;
      $display("FAIL spur_late got ack=%b out=%0d req=%b exp 0000/56/0",
               ack, out, mul_req);
    end
  endtask

  task automatic test_random();
    bit ok;
    int g;
    int pick;
    for (int i = 0; i < N; i++)
      if ($urandom_range(0, 1) == 1) begin
        set_op(i, $urandom, $urandom);
        req[i] = 1'b1;
      end
    if (req == '0) begin
      pick = $urandom_range(0, N - 1);
      set_op(pick, $urandom, $urandom);
      req[pick] = 1'b1;
    end
    for (int op = 0; op < 24; op++) begin
      lat = $urandom_range(1, 6);
      g = rr(req, ref_ptr);
      for (int c = 0; c < 20; c++) begin
        tick();
        if (mul_req) break;
      end
      p0_in[g*32 +: 32] = $urandom;
      p1_in[g*32 +: 32] = $urandom;
      wait_ack(40, ok);
      checks++;
      if (!ok || ack !== oh(g) || out !== prod(ea[g], eb[g])) begin
        errors++;
        $display("FAIL random_op%0d got ack=%b out=%h exp %b/%h",
                 op, ack, out, oh(g), prod(ea[g], eb[g]));
      end
      ref_ptr = g;
      req[g] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (req[i] && $urandom_range(0, 4) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0) begin
          set_op(i, $urandom, $urandom);
          req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        pick = $urandom_range(0, N - 1);
        set_op(pick, $urandom, $urandom);
        req[pick] = 1'b1;
      end
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
`ifdef MULARB_TIMEOUT_EN
    bit ok;
    u_en = 1'b0;
    set_op(2, 32'd3, 32'd4);
    req = 4'b0100;
    tick();
    repeat (9) tick();
    checks++;
    if (ack !== '0 || mul_req !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early got ack=%b req=%b exp 0000/1", ack, mul_req);
    end
    tick();
    checks++;
    if (ack !== 4'b0100 || err !== 1'b1 || out !== '0 || mul_req !== 1'b0)
    begin
      errors++;
      $display("FAIL tmo_fire got ack=%b err=%b out=%h req=%b exp 0100/1/0/0",
               ack, err, out, mul_req);
    end
    req = '0;
    ref_ptr = 2;
    tick();
    f_out = 32'h55;
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
    checks++;
    if (ack !== '0 || out !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_stale got ack=%b out=%h err=%b exp 0", ack, out, err);
    end
    u_en = 1'b1;
    lat = 3;
    set_op(0, 32'd9, 32'd9);
    req = 4'b0001;
    wait_ack(30, ok);
    checks++;
    if (!ok || ack !== 4'b0001 || out !== 32'd81 || err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_next got ack=%b out=%0d err=%b exp 0001/81/0",
               ack, out, err);
    end
    ref_ptr = 0;
    req = '0;
    tick();
    tick();
`else
    bit hit;
    hit = 1'b0;
    u_en = 1'b0;
    set_op(2, 32'd3, 32'd4);
    req = 4'b0100;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (ack != '0 || err) hit = 1'b1;
    end
    checks++;
    if (hit || mul_req !== 1'b1) begin
      errors++;
      $display("FAIL wait_forever got ack_seen=%b req=%b exp 0/1",
               hit, mul_req);
    end
    do_reset();
    u_en = 1'b1;
    tick();
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_reset_mid();
    test_spurious();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter that shares one 32x32 iterative multiplier (the `mul32x32_fsm` unit behind `hls_MulFSM`) between up to N HLS requesters. It latches the winning requester's operands and drives the unit's req/ack handshake. It returns the 32-bit product with a one-cycle per-requester ack. It sits between the generated HLS datapaths and a single multiplier instance, so the design needs only one multiplier.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- TIMEOUT, 255, max cycles to wait for the unit's ack (used only with MULARB_TIMEOUT_EN)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- req  input  N  per-requester request; level, held with operands until ack
- p0_in  input  N*32  operand 0, requester i at bits [32*i+31:32*i]
- p1_in  input  N*32  operand 1, same packing
- ack  output  N  one-hot, one-cycle completion pulse
- out  output  32  product; valid in the ack cycle, held until the next completion
- err  output  1  high with ack when the operation timed out
- mul_req  output  1  request to the multiplier unit
- mul_p0  output  32  registered operand 0 to the unit
- mul_p1  output  32  registered operand 1 to the unit
- mul_ack  input  1  unit completion pulse
- mul_out  input  32  unit product, valid while mul_ack is high

## Operation
- The state machine has three states: IDLE, ISSUE and DONE.
- **IDLE:**
  - If any req bit is high, pick winner g by round-robin, searching from ptr+1 upward and wrapping modulo N.
  - Latch p0_in/p1_in slice g into mul_p0/mul_p1.
  - Set ptr = g, set mul_req = 1, go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE:**
  - mul_req is held at 1 and the operands are stable.
  - On mul_ack: latch mul_out into out, set mul_req = 0, pulse ack[g], set err = 0, go to DONE.
- **DONE:** lasts one cycle with ack[g] high, then returns to IDLE.
- **Requester rule:** a requester deasserts req on the clock edge at which it samples its ack high. A req bit still high in IDLE counts as a new request.
- **Ignored inputs:**
  - mul_ack outside ISSUE is ignored, including a late ack.
  - Changes to a request's operands after it is latched are ignored.
  - A req bit dropped by a requester not yet granted is simply not serviced.
- **Arithmetic:** out = mul_out unmodified (low 32 bits of the product, the unit's truncation rule).
- **Fairness:** ptr reset value is N-1, so requester 0 wins first. Under continuous contention, every requester is granted within N operations.
- **Reset:**
  - rst low in any state, including mid-ISSUE, forces IDLE.
  - All outputs reset to 0: mul_req, ack, err, out, mul_p0, mul_p1. ptr resets to N-1.
  - The multiplier unit shares rst, so no operation survives reset.

## Timing
- **Sequence**, with the req sampled in IDLE at edge 0:
  - Cycle 1: ISSUE, mul_req = 1.
  - Unit asserts mul_ack in cycle k.
  - Cycle k+1: DONE, ack[g] = 1, out valid, mul_req = 0.
  - Cycle k+2: IDLE.
- Arbitration overhead is 2 cycles per operation on top of the unit latency.
- The next grant at the earliest is issued at edge k+2; mul_req rises in cycle k+3.
- Between operations, mul_req is low for at least 2 cycles, which satisfies the unit's requirement of one low cycle.
- Outputs are all registered; there are no combinational paths from req to ack or mul_req.

## Configuration
- MULARB_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter counts ISSUE cycles.
  - When TIMEOUT cycles pass without mul_ack, the arbiter goes to DONE with ack[g] = 1, err = 1, out = 0 and mul_req = 0.
  - A subsequent stale mul_ack is ignored.
- MULARB_TIMEOUT_EN undefined: ISSUE waits indefinitely, err is tied 0 and no counter is synthesized.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2);
  - the operand width constant MUL_W = 32;
  - the default N.
- One sub-module, `mul_rr_pick`: combinational. It takes req[N-1:0] and ptr and returns a one-hot grant plus the binary index. It is instanced once.

## Test plan
- **Single request:** req = 4'b0001, p0 = 7, p1 = 6, with a unit model acking 5 cycles after mul_req.
  - Expect mul_req high at cycle 1 with mul_p0 = 7, mul_p1 = 6.
  - Expect ack = 4'b0001 and out = 42 at cycle 7.
- **Contention:** all four requesters held high with distinct operands (i+2)*(i+3).
  - Grants occur in order 0, 1, 2, 3, 0.
  - Outputs are 6, 12, 20, 30.
  - mul_req is low for at least 2 cycles between operations.
- **Wrap and truncation:** operands 0xFFFFFFFF * 0xFFFFFFFF with requester 2 only.
  - Expect out = 0x00000001.
  - Expect ptr wrap: a subsequent req 4'b0011 grants requester 0 before requester 1.
- **Reset mid-ISSUE:** assert rst low during cycle 3 of an operation.
  - The next cycle shows mul_req = 0, ack = 0 and out = 0.
  - The next request grants requester 0 first.
- **Late and spurious ack:** pulse mul_ack while IDLE.
  - No ack or out change occurs, and the state stays IDLE.
- **MULARB_TIMEOUT_EN with TIMEOUT = 10:** the unit never acks.
  - Cycle 11 shows ack[g] = 1, err = 1, out = 0.
  - A later mul_ack is ignored.
  - The next request completes normally with err = 0.
